// File: rtl/top.sv
// Toroidal 8x8 Game of Life with a WS2812B serializer showing each cell's
// birth (blue), survival (green) and death (red) for the latest generation.
module top #(
  parameter int          CLK_HZ       = 12_000_000,
  parameter int          GEN_CYCLES   = 600_000,
  parameter logic [63:0] INIT_PATTERN = 64'h4020E00000000000,
  parameter logic [7:0]  BRIGHTNESS   = 8'h10
) (
  input  logic clk,
  input  logic rst,
  input  logic SW,
  input  logic BOOT,
  output logic _48b,
  output logic _45a
);

  // WS2812B timing derived from the clock: 1.25 us bit, 0.33/0.75 us high, ~83 us latch
  localparam int T_BIT = CLK_HZ / 800_000;
  localparam int T0H   = CLK_HZ / 3_000_000;
  localparam int T1H   = (CLK_HZ / 4_000_000) * 3;
  localparam int T_GAP = CLK_HZ / 12_000;

  localparam int GEN_W = (GEN_CYCLES > 1) ? $clog2(GEN_CYCLES) : 1;
  localparam int PH_W  = $clog2(T_BIT);
  localparam int GAP_W = $clog2(T_GAP);

  localparam logic [GEN_W-1:0] GEN_LAST = GEN_W'(GEN_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(T_BIT - 1);
  localparam logic [PH_W-1:0]  T0H_V    = PH_W'(T0H);
  localparam logic [PH_W-1:0]  T1H_V    = PH_W'(T1H);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T_GAP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic             sw_p0, sw_p1, boot_p0, boot_p1;
  logic [GEN_W-1:0] gen_cnt;
  logic             tick;
  logic [63:0]      board, prev, next_board;
  logic [3:0]       nbr;
  logic [63:0]      green_output_array, red_output_array, blue_output_array;

  logic [1:0]       state;
  logic [5:0]       led_idx;
  logic [4:0]       sub_idx;
  logic [PH_W-1:0]  phase;
  logic [GAP_W-1:0] gap_cnt;
  logic             frame_start;
  logic [63:0]      g_lat, r_lat, b_lat;
  logic             chan_bit, cur_bit, line_p0, dout_p1;

  function automatic logic [5:0] cell_idx(input int r, input int c);
    return 6'(63 - (8 * r + c));
  endfunction

  // Stage p0 -> p1: button synchronizers (idle high)
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_p0   <= 1'b1;
      sw_p1   <= 1'b1;
      boot_p0 <= 1'b1;
      boot_p1 <= 1'b1;
    end else begin
      sw_p0   <= SW;
      sw_p1   <= sw_p0;
      boot_p0 <= BOOT;
      boot_p1 <= boot_p0;
    end
  end

  assign tick = (gen_cnt == GEN_LAST);

  always_ff @(posedge clk) begin
    if (rst) gen_cnt <= '0;
    else     gen_cnt <= tick ? '0 : gen_cnt + 1'b1;
  end

  always_comb begin
    next_board = '0;
    nbr        = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        nbr = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0)
              nbr = nbr + {3'b000, board[cell_idx((r + dr + 8) % 8, (c + dc + 8) % 8)]};
          end
        end
        next_board[cell_idx(r, c)] = (nbr == 4'd3) || (board[cell_idx(r, c)] && nbr == 4'd2);
      end
    end
  end

  // Reload wins over a generation tick
  always_ff @(posedge clk) begin
    if (rst || !boot_p1) begin
      board <= INIT_PATTERN;
      prev  <= INIT_PATTERN;
    end else if (tick && sw_p1) begin
      prev  <= board;
      board <= next_board;
    end
  end

  assign green_output_array = board & prev;
  assign blue_output_array  = board & ~prev;
  assign red_output_array   = ~board & prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      led_idx <= '0;
      sub_idx <= '0;
      phase   <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_SEND;
        S_SEND: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            if (sub_idx == 5'd23) begin
              sub_idx <= '0;
              led_idx <= led_idx + 1'b1;
              if (led_idx == 6'd63) begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end else begin
              sub_idx <= sub_idx + 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_SEND;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign frame_start = (state == S_IDLE) || (state == S_GAP && gap_cnt == GAP_LAST);

  // Frame snapshot keeps mid-frame generation commits out of the data being sent
  always_ff @(posedge clk) begin
    if (frame_start) begin
      g_lat <= green_output_array;
      r_lat <= red_output_array;
      b_lat <= blue_output_array;
    end
  end

  always_comb begin
    chan_bit = 1'b0;
    case (sub_idx[4:3])
      2'd0:    chan_bit = g_lat[6'd63 - led_idx];
      2'd1:    chan_bit = r_lat[6'd63 - led_idx];
      default: chan_bit = b_lat[6'd63 - led_idx];
    endcase
    cur_bit = chan_bit & BRIGHTNESS[3'd7 - sub_idx[2:0]];
    line_p0 = (state == S_SEND) && (phase < (cur_bit ? T1H_V : T0H_V));
  end

  // Stage p0 -> p1: registered serial line
  always_ff @(posedge clk) begin
    if (rst) dout_p1 <= 1'b0;
    else     dout_p1 <= line_p0;
  end

  assign _48b = dout_p1;
  assign _45a = dout_p1;

endmodule

// File: tb/tb_top.sv
// Directed bench for the Game of Life panel driver: generations, colors,
// pause/reload buttons and the WS2812B frame waveform.
module tb_top;

  localparam int          G      = 40;
  localparam logic [63:0] GLIDER = 64'h4020E00000000000;
  localparam logic [63:0] BLINK  = 64'h0000003800000000;
  localparam logic [63:0] BLOCK  = 64'h8100000000000081;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic SW  = 1'b1;
  logic BOOT = 1'b1;
  logic gl_d, gl_c, bl_d, bl_c, bk_d, bk_c;
  logic [191:0] gl_rgb, bl_rgb, bk_rgb;

  int passes = 0;
  int checks = 0;

  // Hand-derived glider generations 0..4
  logic [63:0] glider_gen [0:4] = '{64'h4020E00000000000, 64'h00A0604000000000,
                                    64'h0020A06000000000, 64'h0040306000000000,
                                    64'h0020107000000000};

  always #5 clk = ~clk;

  top #(.GEN_CYCLES(G)) u_glider (
    .clk(clk), .rst(rst), .SW(SW), .BOOT(BOOT), ._48b(gl_d), ._45a(gl_c));
  top #(.GEN_CYCLES(G), .INIT_PATTERN(BLINK)) u_blink (
    .clk(clk), .rst(rst), .SW(SW), .BOOT(BOOT), ._48b(bl_d), ._45a(bl_c));
  top #(.GEN_CYCLES(G), .INIT_PATTERN(BLOCK)) u_block (
    .clk(clk), .rst(rst), .SW(SW), .BOOT(BOOT), ._48b(bk_d), ._45a(bk_c));

  assign gl_rgb = {u_glider.green_output_array, u_glider.red_output_array, u_glider.blue_output_array};
  assign bl_rgb = {u_blink.green_output_array, u_blink.red_output_array, u_blink.blue_output_array};
  assign bk_rgb = {u_block.green_output_array, u_block.red_output_array, u_block.blue_output_array};

  // {green, red, blue} expected from the new and the previous board
  function automatic logic [191:0] colors(input logic [63:0] nb, input logic [63:0] ob);
    return {nb & ob, ~nb & ob, nb & ~ob};
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    wait_edges(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    SW = 1'b1; BOOT = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    wait_edges(2);
    checks++;
    if ({gl_d, gl_c} !== 2'b00) $display("FAIL reset_line: got %b%b need 00", gl_d, gl_c);
    else passes++;
    checks++;
    if (gl_rgb !== {GLIDER, 64'h0, 64'h0}) $display("FAIL reset_glider_rgb: got %h need %h", gl_rgb, {GLIDER, 128'h0});
    else passes++;
    checks++;
    if (bl_rgb !== {BLINK, 64'h0, 64'h0}) $display("FAIL reset_blink_rgb: got %h need %h", bl_rgb, {BLINK, 128'h0});
    else passes++;
    checks++;
    if (bk_rgb !== {BLOCK, 64'h0, 64'h0}) $display("FAIL reset_block_rgb: got %h need %h", bk_rgb, {BLOCK, 128'h0});
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_frame();
    int h, l, wt, terr, cerr, tail;
    logic [23:0] word, expw;
    logic [63:0] pat;
    pat = GLIDER;
    SW = 1'b1; BOOT = 1'b1;
    apply_reset();
    wt = 0;
    @(negedge clk);
    while (gl_d !== 1'b1 && wt < 50) begin @(negedge clk); wt++; end
    checks++;
    if (gl_d !== 1'b1) begin
      $display("FAIL frame_start: _48b=%b after %0d clk, need 1 within 50", gl_d, wt);
      return;
    end
    passes++;
    terr = 0; cerr = 0; tail = 0;
    for (int led = 0; led < 64 && terr <= 8; led++) begin
      word = '0;
      for (int b = 0; b < 24; b++) begin
        h = 0;
        while (gl_d === 1'b1 && h < 40) begin if (gl_c !== gl_d) cerr++; h++; @(negedge clk); end
        l = 0;
        while (gl_d === 1'b0 && l < 1100) begin if (gl_c !== gl_d) cerr++; l++; @(negedge clk); end
        if (h != 4 && h != 9) terr++;
        if (led == 63 && b == 23) tail = h + l;
        else if (h + l != 15) terr++;
        word = {word[22:0], (h == 9)};
      end
      expw = {(pat[63 - led] ? 8'h10 : 8'h00), 16'h0000};
      checks++;
      if (word !== expw) $display("FAIL frame_led%0d: got GRB %h need %h", led, word, expw);
      else passes++;
    end
    checks++;
    if (terr != 0) $display("FAIL frame_bit_timing: got %0d bad bits need 0", terr);
    else passes++;
    checks++;
    if (cerr != 0) $display("FAIL frame_copy: got %0d _45a differences need 0", cerr);
    else passes++;
    checks++;
    if (tail != 1015) $display("FAIL frame_latch: got last bit + gap %0d clk need 1015", tail);
    else passes++;
  endtask

  task automatic test_glider();
    SW = 1'b1; BOOT = 1'b1;
    apply_reset();
    wait_edges(G - 1);
    checks++;
    if (gl_rgb !== {GLIDER, 128'h0}) $display("FAIL glider_early: got %h need %h", gl_rgb, {GLIDER, 128'h0});
    else passes++;
    wait_edges(1);
    for (int t = 1; t <= 4; t++) begin
      if (t > 1) wait_edges(G);
      checks++;
      if (gl_rgb !== colors(glider_gen[t], glider_gen[t-1]))
        $display("FAIL glider_tick%0d: got %h need %h", t, gl_rgb, colors(glider_gen[t], glider_gen[t-1]));
      else passes++;
    end
    checks++;
    if ((u_glider.green_output_array | u_glider.blue_output_array) !== (GLIDER >> 9))
      $display("FAIL glider_moved: got %h need %h",
               u_glider.green_output_array | u_glider.blue_output_array, GLIDER >> 9);
    else passes++;
  endtask

  task automatic test_blinker();
    SW = 1'b1; BOOT = 1'b1;
    apply_reset();
    wait_edges(G);
    checks++;
    if (bl_rgb !== {64'h0000001000000000, 64'h0000002800000000, 64'h0000100010000000})
      $display("FAIL blink_tick1: got %h need %h", bl_rgb,
               {64'h0000001000000000, 64'h0000002800000000, 64'h0000100010000000});
    else passes++;
    wait_edges(G);
    checks++;
    if (bl_rgb !== {64'h0000001000000000, 64'h0000100010000000, 64'h0000002800000000})
      $display("FAIL blink_tick2: got %h need %h", bl_rgb,
               {64'h0000001000000000, 64'h0000100010000000, 64'h0000002800000000});
    else passes++;
  endtask

  task automatic test_block_wrap();
    SW = 1'b1; BOOT = 1'b1;
    apply_reset();
    for (int t = 1; t <= 5; t++) begin
      wait_edges(G);
      checks++;
      if (bk_rgb !== {BLOCK, 128'h0}) $display("FAIL block_tick%0d: got %h need %h", t, bk_rgb, {BLOCK, 128'h0});
      else passes++;
    end
  endtask

  task automatic test_pause();
    SW = 1'b0; BOOT = 1'b1;
    apply_reset();
    wait_edges(G + 1);
    checks++;
    if (gl_rgb !== {GLIDER, 128'h0}) $display("FAIL pause_tick1: got %h need %h", gl_rgb, {GLIDER, 128'h0});
    else passes++;
    wait_edges(2 * G - 1);
    checks++;
    if (gl_rgb !== {GLIDER, 128'h0}) $display("FAIL pause_tick3: got %h need %h", gl_rgb, {GLIDER, 128'h0});
    else passes++;
    SW = 1'b1;
    wait_edges(G - 1);
    checks++;
    if (gl_rgb !== {GLIDER, 128'h0}) $display("FAIL resume_early: got %h need %h", gl_rgb, {GLIDER, 128'h0});
    else passes++;
    wait_edges(1);
    checks++;
    if (gl_rgb !== colors(glider_gen[1], glider_gen[0]))
      $display("FAIL resume_commit: got %h need %h", gl_rgb, colors(glider_gen[1], glider_gen[0]));
    else passes++;
    wait_edges(G - 1);
    checks++;
    if (gl_rgb !== colors(glider_gen[1], glider_gen[0]))
      $display("FAIL resume_single: got %h need %h", gl_rgb, colors(glider_gen[1], glider_gen[0]));
    else passes++;
  endtask

  task automatic test_boot();
    SW = 1'b1; BOOT = 1'b1;
    apply_reset();
    wait_edges(2 * G + 10);
    checks++;
    if (gl_rgb !== colors(glider_gen[2], glider_gen[1]))
      $display("FAIL boot_before: got %h need %h", gl_rgb, colors(glider_gen[2], glider_gen[1]));
    else passes++;
    BOOT = 1'b0;
    wait_edges(2);
    BOOT = 1'b1;
    wait_edges(1);
    checks++;
    if (gl_rgb !== {GLIDER, 128'h0}) $display("FAIL boot_reload: got %h need %h", gl_rgb, {GLIDER, 128'h0});
    else passes++;
    wait_edges(G - 13);
    checks++;
    if (gl_rgb !== colors(glider_gen[1], glider_gen[0]))
      $display("FAIL boot_restart: got %h need %h", gl_rgb, colors(glider_gen[1], glider_gen[0]));
    else passes++;
    wait_edges(G - 3);
    BOOT = 1'b0;
    wait_edges(3);
    checks++;
    if (gl_rgb !== {GLIDER, 128'h0}) $display("FAIL boot_over_tick: got %h need %h", gl_rgb, {GLIDER, 128'h0});
    else passes++;
    BOOT = 1'b1;
    wait_edges(G);
    checks++;
    if (gl_rgb !== colors(glider_gen[1], glider_gen[0]))
      $display("FAIL boot_after_tick: got %h need %h", gl_rgb, colors(glider_gen[1], glider_gen[0]));
    else passes++;
  endtask

  task automatic test_midframe_reset();
    int wt, h;
    SW = 1'b1; BOOT = 1'b1;
    apply_reset();
    wait_edges(200);
    wt = 0;
    @(negedge clk);
    while (gl_d !== 1'b0 && wt < 40) begin @(negedge clk); wt++; end
    while (gl_d !== 1'b1 && wt < 80) begin @(negedge clk); wt++; end
    @(posedge clk);
    #1;
    checks++;
    if (gl_d !== 1'b1) $display("FAIL midframe_high: got %b need 1 before reset", gl_d);
    else passes++;
    rst = 1'b1;
    wait_edges(1);
    checks++;
    if ({gl_d, gl_c} !== 2'b00) $display("FAIL midframe_abort: got %b%b need 00", gl_d, gl_c);
    else passes++;
    wait_edges(3);
    checks++;
    if ({gl_d, gl_rgb} !== {1'b0, GLIDER, 128'h0})
      $display("FAIL midframe_hold: got %b %h need 0 %h", gl_d, gl_rgb, {GLIDER, 128'h0});
    else passes++;
    rst = 1'b0;
    wt = 0;
    @(negedge clk);
    while (gl_d !== 1'b1 && wt < 50) begin @(negedge clk); wt++; end
    h = 0;
    while (gl_d === 1'b1 && h < 40) begin h++; @(negedge clk); end
    checks++;
    if (h != 4) $display("FAIL midframe_restart: got first high %0d clk need 4", h);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_glider();
    test_blinker();
    test_block_wrap();
    test_pause();
    test_boot();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
